// File: rtl/deserialiser_word_packer_if.sv
// RX byte/FIFO bus between the UART-side deserialiser and its neighbours.
// Byte input, FIFO write side and status outputs.
interface deserialiser_word_packer_if #(
  parameter int COUNT_WIDTH = 16
);
  logic [7:0]             i_rx_byte_data;
  logic                   i_rx_byte_valid;
  logic                   i_fifo_full;
  logic [31:0]            o_fifo_word_data;
  logic                   o_fifo_wr_en;
  logic                   o_deserial_busy;
  logic                   o_timeout_err;
  logic                   o_overflow_err;
  logic [COUNT_WIDTH-1:0] o_word_count;

  modport master (
    output i_rx_byte_data,
    output i_rx_byte_valid,
    output i_fifo_full,
    input  o_fifo_word_data,
    input  o_fifo_wr_en,
    input  o_deserial_busy,
    input  o_timeout_err,
    input  o_overflow_err,
    input  o_word_count
  );

  modport slave (
    input  i_rx_byte_data,
    input  i_rx_byte_valid,
    input  i_fifo_full,
    output o_fifo_word_data,
    output o_fifo_wr_en,
    output o_deserial_busy,
    output o_timeout_err,
    output o_overflow_err,
    output o_word_count
  );
endinterface

// File: rtl/deserialiser_word_packer.sv
// Packs UART RX bytes MSB-first into 32-bit words for the RX FIFO,
// with inter-byte timeout and back-pressure overflow supervision.
module deserialiser_word_packer #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int COUNT_WIDTH    = 16
) (
  input logic                     i_clock,
  input logic                     i_reset,
  deserialiser_word_packer_if.slave bus
);

  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [31:0]            word_q, word_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   valid_prev_q, valid_prev_d;
  logic [31:0]            data_q, data_d;
  logic                   wr_en_q, wr_en_d;
  logic                   busy_q, busy_d;
  logic                   to_q, to_d;
  logic                   ov_q, ov_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   byte_stb;

  assign byte_stb = bus.i_rx_byte_valid & ~valid_prev_q;

  // Next-state: byte capture, word hand-off, timeout and overflow
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    timer_d      = timer_q;
    valid_prev_d = bus.i_rx_byte_valid;
    data_d       = data_q;
    wr_en_d      = 1'b0;
    to_d         = 1'b0;
    ov_d         = 1'b0;
    cnt_d        = cnt_q;

    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (byte_stb) begin
          word_d  = {bus.i_rx_byte_data, 24'h0};
          idx_d   = 2'd1;
          timer_d = '0;
          state_d = S_COLLECT;
        end
      end
      (state_q == S_COLLECT): begin
        if (byte_stb) begin
          timer_d = '0;
          case (idx_q)
            2'd1:    word_d[23:16] = bus.i_rx_byte_data;
            2'd2:    word_d[15:8]  = bus.i_rx_byte_data;
            default: word_d[7:0]   = bus.i_rx_byte_data;
          endcase
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (!bus.i_fifo_full) begin
              data_d  = word_d;
              wr_en_d = 1'b1;
              cnt_d   = cnt_q + 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (timer_q == T_LAST) begin
          to_d    = 1'b1;
          idx_d   = 2'd0;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      (state_q == S_WAIT): begin
        if (!bus.i_fifo_full) begin
          data_d  = word_q;
          wr_en_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
          if (byte_stb) begin
            word_d  = {bus.i_rx_byte_data, 24'h0};
            idx_d   = 2'd1;
            timer_d = '0;
            state_d = S_COLLECT;
          end
        end else if (byte_stb) begin
          ov_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      word_q       <= '0;
      timer_q      <= '0;
      valid_prev_q <= 1'b1;
      data_q       <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      to_q         <= 1'b0;
      ov_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      timer_q      <= timer_d;
      valid_prev_q <= valid_prev_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      to_q         <= to_d;
      ov_q         <= ov_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.o_fifo_word_data = data_q;
  assign bus.o_fifo_wr_en     = wr_en_q;
  assign bus.o_deserial_busy  = busy_q;
  assign bus.o_timeout_err    = to_q;
  assign bus.o_overflow_err   = ov_q;
  assign bus.o_word_count     = cnt_q;

endmodule

// File: tb/tb_deserialiser_word_packer.sv
// Bench for deserialiser_word_packer: directed scenarios plus
// random streams against a queue-based reference model.
module tb_deserialiser_word_packer;

  localparam int TO = 16;
  localparam int CW = 4;

  typedef struct {
    logic [31:0] d;
    int          c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   state_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  deserialiser_word_packer_if #(.COUNT_WIDTH(CW)) bus ();

  deserialiser_word_packer #(
    .TIMEOUT_CYCLES(TO),
    .COUNT_WIDTH(CW)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  ev_t exp_wr[$], act_wr[$];
  int  exp_to[$], act_to[$];
  int  exp_ov[$], act_ov[$];

  bit          m_prev;
  logic [7:0]  m_bytes[$];
  bit          m_held;
  logic [31:0] m_hword;
  int          m_idle;
  logic [CW-1:0] m_cnt;
  logic [31:0] m_data;
  bit          m_busy;

  // Reference model: byte list per word, idle counter, held word
  always @(posedge clk or posedge rst) begin
    bit stb;
    int at;
    logic [31:0] w;
    if (rst) begin
      m_prev = 1'b1;
      m_bytes.delete();
      m_held = 1'b0;
      m_idle = 0;
      m_cnt  = '0;
      m_data = '0;
      m_busy = 1'b0;
    end else begin
      stb    = bus.i_rx_byte_valid && !m_prev;
      m_prev = bus.i_rx_byte_valid;
      at     = cyc + 1;
      if (m_held) begin
        if (!bus.i_fifo_full) begin
          exp_wr.push_back('{d: m_hword, c: at});
          m_data = m_hword;
          m_cnt  = m_cnt + 1'b1;
          m_held = 1'b0;
          if (stb) begin
            m_bytes.push_back(bus.i_rx_byte_data);
            m_idle = 0;
          end
        end else if (stb) begin
          exp_ov.push_back(at);
        end
      end else if (stb) begin
        m_bytes.push_back(bus.i_rx_byte_data);
        m_idle = 0;
        if (m_bytes.size() == 4) begin
          w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_bytes.delete();
          if (bus.i_fifo_full) begin
            m_held  = 1'b1;
            m_hword = w;
          end else begin
            exp_wr.push_back('{d: w, c: at});
            m_data = w;
            m_cnt  = m_cnt + 1'b1;
          end
        end
      end else if (m_bytes.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          exp_to.push_back(at);
          m_bytes.delete();
          m_idle = 0;
        end
      end
      m_busy = m_held || (m_bytes.size() > 0);
    end
  end

  // Output monitor: log pulses, track steady-state agreement
  always @(negedge clk) begin
    if (bus.o_fifo_wr_en)
      act_wr.push_back('{d: bus.o_fifo_word_data, c: cyc});
    if (bus.o_timeout_err) act_to.push_back(cyc);
    if (bus.o_overflow_err) act_ov.push_back(cyc);
    if (bus.o_deserial_busy !== m_busy ||
        bus.o_word_count !== m_cnt ||
        bus.o_fifo_word_data !== m_data)
      state_bad++;
  end

  task automatic clear_logs();
    exp_wr.delete(); act_wr.delete();
    exp_to.delete(); act_to.delete();
    exp_ov.delete(); act_ov.delete();
    state_bad = 0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int hold, input int gap);
    bus.i_rx_byte_valid = 1'b1;
    bus.i_rx_byte_data  = b;
    repeat (hold) @(negedge clk);
    bus.i_rx_byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int hold);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], hold, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_rx_byte_valid = 1'b0;
    bus.i_rx_byte_data  = 8'h00;
    bus.i_fifo_full     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_fifo_wr_en, bus.o_timeout_err, bus.o_overflow_err,
         bus.o_deserial_busy} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000",
        {bus.o_fifo_wr_en, bus.o_timeout_err, bus.o_overflow_err,
         bus.o_deserial_busy});
    else passed++;
    checks++;
    if (bus.o_fifo_word_data !== 32'h0 || bus.o_word_count !== '0)
      $display("FAIL reset_data: got %h/%h want 0/0",
        bus.o_fifo_word_data, bus.o_word_count);
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
  endtask

  task automatic test_single_pulse();
    clear_logs();
    send_word(32'hDEADBEEF, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (act_wr.size() !== 1)
      $display("FAIL pulse_wr_count: got %0d want 1", act_wr.size());
    else passed++;
    checks++;
    if (act_wr[0].d !== 32'hDEADBEEF)
      $display("FAIL pulse_data: got %h want deadbeef", act_wr[0].d);
    else passed++;
    checks++;
    if (act_wr[0].c !== exp_wr[0].c)
      $display("FAIL pulse_latency: got cyc %0d want %0d",
        act_wr[0].c, exp_wr[0].c);
    else passed++;
    checks++;
    if (bus.o_word_count !== CW'(1))
      $display("FAIL pulse_count: got %0d want 1", bus.o_word_count);
    else passed++;
  endtask

  task automatic test_held_valid();
    clear_logs();
    send_word(32'hDEADBEEF, 2);
    repeat (3) @(negedge clk);
    checks++;
    if (act_wr.size() !== 1 || act_wr[0].d !== 32'hDEADBEEF)
      $display("FAIL held_write: got %0d writes data %h want 1 deadbeef",
        act_wr.size(), act_wr[0].d);
    else passed++;
    checks++;
    if (bus.o_word_count !== CW'(2) || state_bad !== 0)
      $display("FAIL held_state: count %0d bad %0d want 2 0",
        bus.o_word_count, state_bad);
    else passed++;
  endtask

  task automatic test_timeout();
    clear_logs();
    send_byte(8'($urandom), 1, 1);
    send_byte(8'($urandom), 1, 20);
    checks++;
    if (act_to.size() !== 1 || act_wr.size() !== 0)
      $display("FAIL timeout_pulse: got %0d to %0d wr want 1 0",
        act_to.size(), act_wr.size());
    else passed++;
    checks++;
    if (act_to[0] !== exp_to[0])
      $display("FAIL timeout_cycle: got %0d want %0d",
        act_to[0], exp_to[0]);
    else passed++;
    send_word(32'h11223344, 1);
    repeat (2) @(negedge clk);
    checks++;
    if (act_wr.size() !== 1 || act_wr[0].d !== 32'h11223344)
      $display("FAIL timeout_next: got %0d writes data %h want 11223344",
        act_wr.size(), act_wr[0].d);
    else passed++;
    clear_logs();
    send_byte(8'hC1, 1, TO - 1);
    send_byte(8'hC2, 1, TO - 1);
    send_byte(8'hC3, 1, TO - 1);
    send_byte(8'hC4, 1, 3);
    checks++;
    if (act_to.size() !== 0 || act_wr.size() !== 1 ||
        act_wr[0].d !== 32'hC1C2C3C4)
      $display("FAIL timeout_edge_byte: to %0d wr %0d data %h want 0 1 c1c2c3c4",
        act_to.size(), act_wr.size(), act_wr[0].d);
    else passed++;
  endtask

  task automatic test_backpressure();
    clear_logs();
    send_byte(8'h01, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h03, 1, 1);
    bus.i_fifo_full = 1'b1;
    send_byte(8'h04, 1, 1);
    send_byte(8'h55, 1, 3);
    checks++;
    if (act_ov.size() !== 1 || act_wr.size() !== 0 ||
        bus.o_deserial_busy !== 1'b1)
      $display("FAIL bp_hold: ov %0d wr %0d busy %b want 1 0 1",
        act_ov.size(), act_wr.size(), bus.o_deserial_busy);
    else passed++;
    bus.i_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (act_wr.size() !== 1 || act_wr[0].d !== 32'h01020304 ||
        act_ov.size() !== 1)
      $display("FAIL bp_release: wr %0d data %h ov %0d want 1 01020304 1",
        act_wr.size(), act_wr[0].d, act_ov.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    clear_logs();
    w = $urandom;
    bus.i_fifo_full = 1'b1;
    send_word(w, 1);
    repeat (2) @(negedge clk);
    bus.i_fifo_full = 1'b0;
    send_word(32'hAABBCCDD, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (act_wr.size() !== 2)
      $display("FAIL b2b_count: got %0d want 2", act_wr.size());
    else passed++;
    checks++;
    if (act_wr[0].d !== w || act_wr[1].d !== 32'hAABBCCDD)
      $display("FAIL b2b_data: got %h %h want %h aabbccdd",
        act_wr[0].d, act_wr[1].d, w);
    else passed++;
    checks++;
    if (act_wr[0].c !== exp_wr[0].c || act_wr[1].c !== exp_wr[1].c)
      $display("FAIL b2b_timing: got %0d %0d want %0d %0d",
        act_wr[0].c, act_wr[1].c, exp_wr[0].c, exp_wr[1].c);
    else passed++;
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w;
    clear_logs();
    send_byte(8'h71, 1, 1);
    send_byte(8'h72, 1, 1);
    send_byte(8'h73, 1, 1);
    bus.i_rx_byte_valid = 1'b1;
    bus.i_rx_byte_data  = 8'h74;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_deserial_busy !== 1'b0 || bus.o_word_count !== '0 ||
        bus.o_fifo_word_data !== 32'h0)
      $display("FAIL rstmid_outputs: busy %b cnt %0d data %h want 0",
        bus.o_deserial_busy, bus.o_word_count, bus.o_fifo_word_data);
    else passed++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_rx_byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_deserial_busy !== 1'b0 || act_wr.size() !== 0 ||
        act_to.size() !== 0)
      $display("FAIL rstmid_no_byte: busy %b wr %0d to %0d want 0 0 0",
        bus.o_deserial_busy, act_wr.size(), act_to.size());
    else passed++;
    w = $urandom;
    send_word(w, 1);
    repeat (2) @(negedge clk);
    checks++;
    if (act_wr.size() !== 1 || act_wr[0].d !== w ||
        bus.o_word_count !== CW'(1))
      $display("FAIL rstmid_clean: wr %0d data %h cnt %0d want 1 %h 1",
        act_wr.size(), act_wr[0].d, bus.o_word_count, w);
    else passed++;
    for (int i = 0; i < (1 << CW) - 1; i++) send_word($urandom, 1);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_word_count !== '0 || act_wr.size() !== (1 << CW))
      $display("FAIL count_wrap: cnt %0d wr %0d want 0 %0d",
        bus.o_word_count, act_wr.size(), 1 << CW);
    else passed++;
  endtask

  task automatic test_random();
    int gap;
    clear_logs();
    for (int i = 0; i < 120; i++) begin
      bus.i_fifo_full = ($urandom_range(0, 5) == 0);
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2)
                                        : $urandom_range(1, 3);
      send_byte(8'($urandom), $urandom_range(1, 3), gap);
    end
    bus.i_fifo_full = 1'b0;
    repeat (TO + 4) @(negedge clk);
    checks++;
    if (act_wr.size() !== exp_wr.size() ||
        act_to.size() !== exp_to.size() ||
        act_ov.size() !== exp_ov.size())
      $display("FAIL rand_counts: wr/to/ov %0d/%0d/%0d want %0d/%0d/%0d",
        act_wr.size(), act_to.size(), act_ov.size(),
        exp_wr.size(), exp_to.size(), exp_ov.size());
    else passed++;
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++) begin
      checks++;
      if (act_wr[i].d !== exp_wr[i].d || act_wr[i].c !== exp_wr[i].c)
        $display("FAIL rand_write[%0d]: got %h@%0d want %h@%0d", i,
          act_wr[i].d, act_wr[i].c, exp_wr[i].d, exp_wr[i].c);
      else passed++;
    end
    for (int i = 0; i < exp_to.size() && i < act_to.size(); i++) begin
      checks++;
      if (act_to[i] !== exp_to[i])
        $display("FAIL rand_timeout[%0d]: got %0d want %0d", i,
          act_to[i], exp_to[i]);
      else passed++;
    end
    for (int i = 0; i < exp_ov.size() && i < act_ov.size(); i++) begin
      checks++;
      if (act_ov[i] !== exp_ov[i])
        $display("FAIL rand_overflow[%0d]: got %0d want %0d", i,
          act_ov[i], exp_ov[i]);
      else passed++;
    end
    checks++;
    if (state_bad !== 0)
      $display("FAIL rand_state: got %0d bad cycles want 0", state_bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_held_valid();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
